// File: rtl/stall_scoreboard.sv
// Hazard-detection scoreboard for an in-order pipeline: tracks per-register result
// latency and multiplier occupancy, and holds the IF/ID instruction while a hazard exists.
module stall_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rs_used_i,
  input  logic              rt_used_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              wr_en_i,
  input  logic              is_load_i,
  input  logic              is_mul_i,
  input  logic              flush_i,
  output logic              PCWrite_o,
  output logic              IF_IDWrite_o,
  output logic              bubble_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int NREG = 2 ** REG_AW;

  // Issue rule: the IF/ID instruction issues on an edge where issue_valid_i=1,
  // flush_i=0 and stall=0. Stalled or flushed instructions leave no trace.

  logic [CNT_W-1:0] pend [NREG];
  logic [CNT_W-1:0] mul_busy;
  logic [15:0]      stall_cnt;

  logic [CNT_W-1:0] lat;
  logic             raw_rs;
  logic             raw_rt;
  logic             raw_hz;
  logic             waw_hz;
  logic             struct_hz;
  logic             stall;
  logic             issue;

  always_comb begin
    lat = '0;
    if (is_load_i) begin
      lat = CNT_W'(LOAD_LAT);
    end else if (is_mul_i) begin
      lat = CNT_W'(MUL_LAT);
    end
  end

  // Register 0 is excluded explicitly even though its counter is held at zero.
  assign raw_rs    = rs_used_i && (rs_i != '0) && (pend[rs_i] != '0);
  assign raw_rt    = rt_used_i && (rt_i != '0) && (pend[rt_i] != '0);
  assign raw_hz    = raw_rs || raw_rt;
  assign waw_hz    = wr_en_i && (rd_i != '0) && (pend[rd_i] > lat);
  assign struct_hz = is_mul_i && (mul_busy != '0);

  assign stall = issue_valid_i && !flush_i && (raw_hz || waw_hz || struct_hz);
  assign issue = issue_valid_i && !flush_i && !stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (issue && wr_en_i && (rd_i == REG_AW'(r)) && (lat != '0)) begin
          pend[r] <= lat;
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mul_busy <= '0;
    end else if (issue && is_mul_i) begin
      mul_busy <= CNT_W'(MUL_LAT);
    end else if (mul_busy != '0) begin
      mul_busy <= mul_busy - 1'b1;
    end
  end

  // Saturating so long-running profiles never wrap back to small values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign PCWrite_o    = !stall;
  assign IF_IDWrite_o = !stall;
  assign bubble_o     = stall;
  assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_stall_scoreboard.sv
// Bench for stall_scoreboard: a ready-time model checked every cycle, directed hazard
// sequences with literal expectations, and a long-latency instance for counter saturation.
module tb_stall_scoreboard;

  localparam int LD_L  = 1;
  localparam int MUL_L = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  // main instance (default parameters)
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, rsu = 1'b0, rtu = 1'b0, wr = 1'b0, ld = 1'b0, mul = 1'b0, flush = 1'b0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       pcw, ifid, bub;
  logic [15:0] cnt;

  stall_scoreboard dut (
    .clk_i(clk), .rst_i(rst_n), .issue_valid_i(valid),
    .rs_i(rs), .rt_i(rt), .rs_used_i(rsu), .rt_used_i(rtu),
    .rd_i(rd), .wr_en_i(wr), .is_load_i(ld), .is_mul_i(mul), .flush_i(flush),
    .PCWrite_o(pcw), .IF_IDWrite_o(ifid), .bubble_o(bub), .stall_cnt_o(cnt)
  );

  // long-latency instance: mul r7 <- r7 repeats, stalling 255 of every 256 cycles
  logic        s_rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_pcw, s_ifid, s_bub;
  logic [15:0] s_cnt;

  stall_scoreboard #(.REG_AW(5), .CNT_W(8), .LOAD_LAT(1), .MUL_LAT(255)) dut_sat (
    .clk_i(clk), .rst_i(s_rst), .issue_valid_i(s_valid),
    .rs_i(5'd7), .rt_i(5'd0), .rs_used_i(1'b1), .rt_used_i(1'b0),
    .rd_i(5'd7), .wr_en_i(1'b1), .is_load_i(1'b0), .is_mul_i(1'b1), .flush_i(1'b0),
    .PCWrite_o(s_pcw), .IF_IDWrite_o(s_ifid), .bubble_o(s_bub), .stall_cnt_o(s_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each register has the cycle number from which it is readable again.
  int cyc = 0;
  int ready[32];
  int mul_ready = 0;
  int m_cnt = 0;

  function automatic int m_lat();
    return ld ? LD_L : (mul ? MUL_L : 0);
  endfunction

  function automatic logic m_stall();
    logic raw, waw, str;
    raw = (rsu && rs != 0 && ready[rs] > cyc) || (rtu && rt != 0 && ready[rt] > cyc);
    waw = wr && rd != 0 && ready[rd] > cyc + m_lat();
    str = mul && mul_ready > cyc;
    return valid && !flush && (raw || waw || str);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (ready[i]) ready[i] = 0;
      mul_ready = 0;
      m_cnt = 0;
    end else begin
      if (m_stall()) begin
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      end else if (valid && !flush) begin
        if (wr && rd != 0 && m_lat() > 0) ready[rd] = cyc + 1 + m_lat();
        if (mul) mul_ready = cyc + 1 + MUL_L;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic st;
    st = m_stall();
    chk("cmp_pcwrite", int'(pcw), int'(!st));
    chk("cmp_ifidwrite", int'(ifid), int'(!st));
    chk("cmp_bubble", int'(bub), int'(st));
    chk("cmp_stall_cnt", int'(cnt), m_cnt);
  end

  task automatic drv(input logic v, input logic [4:0] a, input logic au, input logic [4:0] b,
                     input logic bu, input logic [4:0] d, input logic w, input logic l,
                     input logic m, input logic f);
    valid = v; rs = a; rsu = au; rt = b; rtu = bu; rd = d; wr = w; ld = l; mul = m; flush = f;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string name, input logic p, input logic b, input logic [15:0] c);
    logic [17:0] e;
    exp_q.push_back({p, b, c});
    #1;
    e = exp_q.pop_front();
    chk({name, "_pcwrite"}, int'(pcw), int'(e[17]));
    chk({name, "_ifidwrite"}, int'(ifid), int'(e[17]));
    chk({name, "_bubble"}, int'(bub), int'(e[16]));
    chk({name, "_cnt"}, int'(cnt), int'(e[15:0]));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    out("reset", 1'b1, 1'b0, 16'd0);
    chk("reset_sat_cnt", int'(s_cnt), 0);
    rst_n = 1'b1;
    s_rst = 1'b1;

    // load r5, then add r6 = r5 + r1: one bubble
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);  out("ld_issue", 1, 0, 0);   tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);  out("ld_use_s1", 0, 1, 0);  tick();
    out("ld_use_go", 1, 0, 1);  tick();
    idle();  out("idle_a", 1, 0, 1);  tick();

    // mul r7, then consumer reading r7 on rt: three bubbles
    drv(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);  out("mul7_issue", 1, 0, 1);  tick();
    drv(1, 2, 1, 7, 1, 9, 1, 0, 0, 0);  out("mul_raw_s1", 0, 1, 1);  tick();
    out("mul_raw_s2", 0, 1, 2);  tick();
    out("mul_raw_s3", 0, 1, 3);  tick();
    out("mul_raw_go", 1, 0, 4);  tick();

    // back-to-back independent muls: structural stall of three
    drv(1, 1, 1, 2, 1, 10, 1, 0, 1, 0);  out("mul10_issue", 1, 0, 4);  tick();
    drv(1, 3, 1, 4, 1, 11, 1, 0, 1, 0);  out("struct_s1", 0, 1, 4);  tick();
    out("struct_s2", 0, 1, 5);  tick();
    out("struct_s3", 0, 1, 6);  tick();
    out("struct_go", 1, 0, 7);  tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      out("drain_b", 1, 0, 7);  tick();
    end

    // mul r8, then ALU write to r8: WAW stall until r8 drains
    drv(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);  out("mul8_issue", 1, 0, 7);  tick();
    drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);  out("waw_s1", 0, 1, 7);  tick();
    out("waw_s2", 0, 1, 8);  tick();
    out("waw_s3", 0, 1, 9);  tick();
    out("waw_go", 1, 0, 10);  tick();
    idle();  out("idle_c", 1, 0, 10);  tick();

    // load r5, flushed dependent mul writing r5, then a mul reading r5
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);  out("ld5_issue", 1, 0, 10);  tick();
    drv(1, 5, 1, 0, 0, 5, 1, 0, 1, 1);  out("flush_nostall", 1, 0, 10);  tick();
    drv(1, 5, 1, 0, 0, 12, 1, 0, 1, 0); out("flush_no_effect", 1, 0, 10);  tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      out("drain_d", 1, 0, 10);  tick();
    end

    // load to r0 never blocks a reader of r0
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);  out("ld_r0", 1, 0, 10);  tick();
    drv(1, 0, 1, 0, 1, 13, 1, 0, 0, 0); out("r0_use", 1, 0, 10);  tick();

    // reset mid-stall clears everything without a clock edge
    drv(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);  out("mul7b_issue", 1, 0, 10);  tick();
    drv(1, 7, 1, 0, 0, 9, 1, 0, 0, 0);  out("pre_rst_stall", 0, 1, 10);
    rst_n = 1'b0;
    out("rst_async", 1, 0, 0);
    tick();
    rst_n = 1'b1;
    out("post_rst", 1, 0, 0);  tick();
    idle();  out("idle_e", 1, 0, 0);  tick();

    // saturation on the long-latency instance
    s_valid = 1'b1;
    #1;
    chk("sat_first_issue", int'(s_bub), 0);
    repeat (256) @(posedge clk);
    #1;
    chk("sat_reissue_bubble", int'(s_bub), 0);
    chk("sat_cnt_255", int'(s_cnt), 255);
    repeat (66001 - 256) @(posedge clk);
    #1;
    chk("sat_midstall_bubble", int'(s_bub), 1);
    chk("sat_cnt_ffff", int'(s_cnt), 16'hFFFF);
    s_rst = 1'b0;
    #1;
    chk("sat_rst_pcwrite", int'(s_pcw), 1);
    chk("sat_rst_ifidwrite", int'(s_ifid), 1);
    chk("sat_rst_bubble", int'(s_bub), 0);
    chk("sat_rst_cnt", int'(s_cnt), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
